// File: rtl/ternary_memory.sv
// Memory responder for the ternary CPU: registered fetch/load reads, stores,
// and a streaming program loader that fills RAM after reset before the CPU runs.
module ternary_memory #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2*MEM_ADDR_SIZE-1:0]   mem_address,
  input  logic [2*WORD_SIZE-1:0]       mem_write_data,
  input  logic                         mem_read,
  input  logic                         mem_write,
  output logic [2*WORD_SIZE-1:0]       mem_read_data,
  input  logic                         load_valid,
  input  logic [2*WORD_SIZE-1:0]       load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         busy,
  output logic                         fault
);

  // state   | meaning
  // LOAD    | loader streams words into RAM, CPU strobes ignored
  // RUN     | CPU reads/writes serviced until the next reset

  localparam int DEPTH = 3 ** MEM_ADDR_SIZE;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW    = 2 * MEM_ADDR_SIZE;
  localparam int DW    = 2 * WORD_SIZE;

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'((DEPTH - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic addr_ok_f(input logic [AW-1:0] a);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      if (a[2*i +: 2] == 2'b11) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic data_ok_f(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (d[2*i +: 2] == 2'b11) ok = 1'b0;
    end
    return ok;
  endfunction

  // Balanced-ternary address offset so that address 0 lands mid-array.
  function automatic logic [IDX_W-1:0] addr_index_f(input logic [AW-1:0] a);
    int acc;
    int w;
    acc = (DEPTH - 1) / 2;
    w   = 1;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      case (a[2*i +: 2])
        2'b01:   acc = acc + w;
        2'b10:   acc = acc - w;
        default: acc = acc;
      endcase
      w = w * 3;
    end
    return IDX_W'(acc);
  endfunction

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] remain_q, remain_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             fault_q, fault_d;

  logic [DW-1:0]    ram_q [DEPTH];
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [DW-1:0]    ram_wdata;

  logic             addr_ok;
  logic             wdata_ok;
  logic             ldata_ok;
  logic [IDX_W-1:0] cpu_idx;

  assign addr_ok  = addr_ok_f(mem_address);
  assign wdata_ok = data_ok_f(mem_write_data);
  assign ldata_ok = data_ok_f(load_data);
  assign cpu_idx  = addr_index_f(mem_address);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    ram_we    = 1'b0;
    ram_waddr = ptr_q;
    ram_wdata = load_data;

    case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          if (ldata_ok) ram_we = 1'b1;
          else          fault_d = 1'b1;
          ptr_d    = (ptr_q == IDX_LAST) ? '0 : ptr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (load_last || (remain_q == '0)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((mem_read || mem_write) && !addr_ok) fault_d = 1'b1;
        if (mem_read) rdata_d = addr_ok ? ram_q[cpu_idx] : '0;
        if (mem_write && addr_ok) begin
          if (wdata_ok) begin
            ram_we    = 1'b1;
            ram_waddr = cpu_idx;
            ram_wdata = mem_write_data;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // RAM has no reset of its own, so block writes on any edge seen under reset.
    if (reset) ram_we = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      ptr_q    <= IDX_ZERO;
      remain_q <= IDX_LAST;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  assign mem_read_data = rdata_q;
  assign load_ready    = (state_q == ST_LOAD);
  assign busy          = (state_q == ST_LOAD);
  assign fault         = fault_q;

endmodule

// File: tb/tb_ternary_memory.sv
// Scoreboard bench for ternary_memory: loader, wrap, store/load, collision,
// fault and asynchronous-reset scenarios against a word-array reference.
module tb_ternary_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  mem_address;
  logic [17:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [17:0] mem_read_data;
  logic        load_valid;
  logic [17:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        busy;
  logic        fault;

  always #5 clock = ~clock;

  ternary_memory #(.WORD_SIZE(9), .MEM_ADDR_SIZE(4)) dut (
    .clock(clock), .reset(reset),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .busy(busy), .fault(fault)
  );

  logic [17:0] model [81];
  logic [17:0] exp_q [$];
  logic [17:0] exp_w;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] to_trits(input int v);
    logic [7:0] t;
    int x;
    int r;
    x = v;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      r = x % 3;
      if (r < 0) r = r + 3;
      if (r == 0) begin t[2*i +: 2] = 2'b00; x = x / 3; end
      else if (r == 1) begin t[2*i +: 2] = 2'b01; x = (x - 1) / 3; end
      else begin t[2*i +: 2] = 2'b10; x = (x + 1) / 3; end
    end
    return t;
  endfunction

  function automatic logic [17:0] rand_word();
    logic [17:0] w;
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 2))
        0:       w[2*i +: 2] = 2'b00;
        1:       w[2*i +: 2] = 2'b01;
        default: w[2*i +: 2] = 2'b10;
      endcase
    end
    return w;
  endfunction

  // All drive tasks start and end on a negedge.
  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic load_word(input logic [17:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    @(negedge clock);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic cpu_cycle(input logic rd, input logic wr, input logic [7:0] a, input logic [17:0] d);
    mem_read = rd; mem_write = wr; mem_address = a; mem_write_data = d;
    @(negedge clock);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic push_read(input int a, input logic [17:0] e);
    exp_q.push_back(e);
    cpu_cycle(1'b1, 1'b0, to_trits(a), '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy got %b expected 1", busy); end
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b expected 1", load_ready); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault got %b expected 0", fault); end
    vectors++; if (mem_read_data !== 18'h0) begin miscompares++; $display("FAIL rst_rdata got %h expected 0", mem_read_data); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load();
    logic [17:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    load_word(w[0], 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy1 got %b expected 1", busy); end
    load_word(w[1], 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy2 got %b expected 1", busy); end
    load_word(w[2], 1'b1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL load_busy3 got %b expected 0", busy); end
    vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL load_ready3 got %b expected 0", load_ready); end
    for (int i = 0; i < 3; i++) model[40+i] = w[i];
    for (int i = 0; i < 3; i++) begin
      push_read(i, model[40+i]);
      exp_w = exp_q.pop_front();
      vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL load_rd%0d got %h expected %h", i, mem_read_data, exp_w); end
    end
    cpu_cycle(1'b0, 1'b0, to_trits(1), '0);
    vectors++; if (mem_read_data !== w[2]) begin miscompares++; $display("FAIL load_hold got %h expected %h", mem_read_data, w[2]); end
  endtask

  task automatic test_wrap();
    logic [17:0] w;
    logic [17:0] w41;
    logic [17:0] w42;
    int rd_addrs [4] = '{40, -40, 0, 13};
    apply_reset();
    for (int k = 1; k <= 81; k++) begin
      w = rand_word();
      if (k == 41) w41 = w;
      if (k == 42) w42 = w;
      model[(40 + k - 1) % 81] = w;
      load_word(w, 1'b0);
      if (k == 80) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wrap_busy80 got %b expected 1", busy); end
      end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_busy81 got %b expected 0", busy); end
    push_read(40, w41);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL wrap_w41 got %h expected %h", mem_read_data, exp_w); end
    push_read(-40, w42);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL wrap_w42 got %h expected %h", mem_read_data, exp_w); end
    for (int i = 0; i < 4; i++) begin
      push_read(rd_addrs[i], model[rd_addrs[i] + 40]);
      exp_w = exp_q.pop_front();
      vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL wrap_rd_a%0d got %h expected %h", rd_addrs[i], mem_read_data, exp_w); end
    end
  endtask

  task automatic test_store_load();
    logic [17:0] p;
    for (int i = 0; i < 9; i++) p[2*i +: 2] = ((i % 3) == 2) ? 2'b10 : 2'b01;
    cpu_cycle(1'b0, 1'b1, to_trits(-40), p);
    model[0] = p;
    push_read(-40, model[0]);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL st_rd got %h expected %h", mem_read_data, exp_w); end
    push_read(40, model[80]);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL st_idx80 got %h expected %h", mem_read_data, exp_w); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL st_fault got %b expected 0", fault); end
  endtask

  task automatic test_collision();
    logic [17:0] nw;
    do nw = rand_word(); while (nw == model[47]);
    exp_q.push_back(model[47]);
    cpu_cycle(1'b1, 1'b1, to_trits(7), nw);
    model[47] = nw;
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL coll_old got %h expected %h", mem_read_data, exp_w); end
    push_read(7, model[47]);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL coll_new got %h expected %h", mem_read_data, exp_w); end
  endtask

  task automatic test_back_to_back();
    int addrs [5] = '{-13, 2, 27, -1, 39};
    for (int i = 0; i < 5; i++) push_read(addrs[i], model[addrs[i] + 40]);
    // Reads above were issued back-to-back; drain while re-reading the tail.
    for (int i = 0; i < 5; i++) exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL b2b_last got %h expected %h", mem_read_data, exp_w); end
  endtask

  task automatic test_faults();
    logic [7:0]  bad;
    logic [17:0] bd;
    bad = to_trits(5);
    bad[3:2] = 2'b11;
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL flt_pre got %b expected 0", fault); end
    exp_q.push_back(18'h0);
    cpu_cycle(1'b1, 1'b0, bad, '0);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL flt_rd got %h expected %h", mem_read_data, exp_w); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL flt_set got %b expected 1", fault); end
    bd = rand_word();
    bd[5:4] = 2'b11;
    cpu_cycle(1'b0, 1'b1, to_trits(3), bd);
    push_read(3, model[43]);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL flt_wdata got %h expected %h", mem_read_data, exp_w); end
    cpu_cycle(1'b0, 1'b1, bad, ~model[48] & 18'h15555);
    push_read(8, model[48]);
    exp_w = exp_q.pop_front();
    vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL flt_waddr got %h expected %h", mem_read_data, exp_w); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL flt_sticky got %b expected 1", fault); end
  endtask

  task automatic test_async_reset();
    logic [17:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = rand_word();
    #2 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ar_run_busy got %b expected 1", busy); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL ar_run_fault got %b expected 0", fault); end
    vectors++; if (mem_read_data !== 18'h0) begin miscompares++; $display("FAIL ar_run_rdata got %h expected 0", mem_read_data); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    load_word(w[0], 1'b0);
    load_word(w[1], 1'b0);
    cpu_cycle(1'b0, 1'b1, to_trits(3), w[5]);
    load_valid = 1'b1; load_data = w[2]; load_last = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL ar_load_ready got %b expected 1", load_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ar_load_busy got %b expected 1", busy); end
    @(negedge clock);
    load_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    load_word(w[3], 1'b0);
    load_word(w[4], 1'b0);
    load_word(w[5], 1'b1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_done got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) model[40+i] = w[3+i];
    for (int i = 0; i < 4; i++) begin
      push_read(i, model[40+i]);
      exp_w = exp_q.pop_front();
      vectors++; if (mem_read_data !== exp_w) begin miscompares++; $display("FAIL ar_rd%0d got %h expected %h", i, mem_read_data, exp_w); end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_address = '0; mem_write_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    @(negedge clock);
    test_reset();
    test_load();
    test_wrap();
    test_store_load();
    test_collision();
    test_back_to_back();
    test_faults();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
